ddr_port_arbiter: RTL

Shares the single DDR command/data port between the ddr2pe loader (read requester) and the pe2ddr saver (write requester). It grants one whole burst at a time with round-robin fairness and forwards the command. It then steers the data beats of that burst, holding the grant until the last beat, and sits between the two DMA engines and the DDR controller.

---
 rtl/ddr_port_arbiter_pkg.sv | 14 +
 rtl/ddr_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types for the DDR port arbiter: FSM state encoding and grant codes.
package ddr_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } arb_state_e;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/ddr_port_arbiter.sv
// DDR port arbiter: shares one DDR command/data port between the loader
// (reads) and the saver (writes). One whole burst is granted at a time,
// round-robin on contention; the command is forwarded, then the data beats of
// that burst are steered combinationally until the last beat.
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // loader (read requester)
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [LEN_W-1:0]  rd_req_len,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_last,
  // saver (write requester)
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [LEN_W-1:0]  wr_req_len,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  input  logic [DATA_W-1:0] wr_data,
  // DDR controller side
  output logic              ddr_cmd_valid,
  input  logic              ddr_cmd_ready,
  output logic [ADDR_W-1:0] ddr_cmd_addr,
  output logic [LEN_W-1:0]  ddr_cmd_len,
  output logic              ddr_cmd_we,
  input  logic              ddr_rdata_valid,
  input  logic [DATA_W-1:0] ddr_rdata,
  output logic              ddr_wdata_valid,
  input  logic              ddr_wdata_ready,
  output logic [DATA_W-1:0] ddr_wdata,
  // status
  output logic              busy,
  output logic              proto_err
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              proto_err_q, proto_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              we_q, we_d;
  logic              grant;

  // Round-robin pick: on contention the side that did not win last time wins.
  function automatic logic pick_grant(input logic rd_v, input logic wr_v,
                                      input logic last);
    if (rd_v && wr_v) return ~last;
    else if (wr_v)    return GRANT_WR;
    else              return GRANT_RD;
  endfunction

  // Data buses are pure pass-throughs; only the qualifiers are gated.
  assign rd_data   = ddr_rdata;
  assign ddr_wdata = wr_data;

  // Next-state, grant, steering and output decode; all outputs forced low in reset.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    beat_cnt_d      = beat_cnt_q;
    proto_err_d     = proto_err_q;
    addr_d          = addr_q;
    len_d           = len_q;
    we_d            = we_q;
    grant           = pick_grant(rd_req_valid, wr_req_valid, last_grant_q);
    rd_req_ready    = 1'b0;
    wr_req_ready    = 1'b0;
    rd_data_valid   = 1'b0;
    rd_data_last    = 1'b0;
    wr_data_ready   = 1'b0;
    ddr_cmd_valid   = 1'b0;
    ddr_cmd_addr    = '0;
    ddr_cmd_len     = '0;
    ddr_cmd_we      = 1'b0;
    ddr_wdata_valid = 1'b0;
    busy            = 1'b0;
    proto_err       = 1'b0;

    if (!rst) begin
      busy         = (state_q != IDLE);
      proto_err    = proto_err_q;
      ddr_cmd_addr = addr_q;
      ddr_cmd_len  = len_q;
      ddr_cmd_we   = we_q;

      unique case (state_q)
        IDLE: begin
          if (rd_req_valid || wr_req_valid) begin
            rd_req_ready = (grant == GRANT_RD);
            wr_req_ready = (grant == GRANT_WR);
            addr_d       = (grant == GRANT_WR) ? wr_req_addr : rd_req_addr;
            len_d        = (grant == GRANT_WR) ? wr_req_len  : rd_req_len;
            we_d         = grant;
            last_grant_d = grant;
            state_d      = CMD;
          end
        end
        CMD: begin
          ddr_cmd_valid = 1'b1;
          if (ddr_cmd_ready) begin
            beat_cnt_d = '0;
            state_d    = we_q ? WDATA : RDATA;
          end
        end
        RDATA: begin
          if (ddr_rdata_valid) begin
            rd_data_valid = 1'b1;
            rd_data_last  = (beat_cnt_q == len_q);
            // Compare precedes increment, so a full 2^LEN_W burst never overflows.
            beat_cnt_d    = beat_cnt_q + 1'b1;
            if (beat_cnt_q == len_q) state_d = IDLE;
          end
        end
        WDATA: begin
          ddr_wdata_valid = wr_data_valid;
          wr_data_ready   = ddr_wdata_ready;
          if (wr_data_valid && ddr_wdata_ready) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == len_q) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // A read beat arriving when no read burst owns the port is dropped and flagged.
      if (ddr_rdata_valid && (state_q != RDATA)) proto_err_d = 1'b1;
    end
  end

  // Control state: FSM, fairness pointer, beat counter and sticky error.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_WR;
      beat_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Latched command fields.
  // NOTE: no reset here; these are only observed after a grant has loaded them.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
    we_q   <= we_d;
  end

endmodule
